// File: rtl/axis_pixels_unpack.sv
// Pixel ingress stage: compacts kept words of wide AXI-Stream beats into a shift buffer
// and emits ROWS-word beats LSB-word-first, zero-padding the final beat of each packet.
module axis_pixels_unpack #(
  parameter int ROWS              = 8,
  parameter int X_BITS            = 4,
  parameter int S_PIXELS_WIDTH_LF = 64,
  localparam int IN_WORDS         = S_PIXELS_WIDTH_LF / X_BITS
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  output logic                         s_ready,
  input  logic                         s_valid,
  input  logic                         s_last,
  input  logic [S_PIXELS_WIDTH_LF-1:0] s_data,
  input  logic [IN_WORDS-1:0]          s_keep,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [ROWS*X_BITS-1:0]       m_data,
  output logic                         m_last
);

  localparam int BUF_WORDS = IN_WORDS + ROWS;
  localparam int BUF_W     = BUF_WORDS * X_BITS;
  localparam int CNT_W     = $clog2(BUF_WORDS + 1);
  localparam int N_W       = $clog2(IN_WORDS + 1);

  logic [BUF_W-1:0] word_buf, buf_pop, buf_d;
  logic [CNT_W-1:0] cnt, cnt_pop, cnt_d;
  logic [N_W-1:0]   n_words;
  logic             last_pend, last_d;
  logic             rst_done;
  logic             pop, push;

  // rst_done keeps s_ready low while reset is held and for the first edge after release
  assign s_ready = rst_done && !last_pend && (cnt <= CNT_W'(ROWS));
  assign m_valid = (cnt >= CNT_W'(ROWS)) || last_pend;
  assign m_last  = last_pend && (cnt <= CNT_W'(ROWS));
  assign pop     = m_valid && m_ready;
  assign push    = s_valid && s_ready;

  genvar r;
  generate
    for (r = 0; r < ROWS; r++) begin : g_out
      assign m_data[r*X_BITS +: X_BITS] = (CNT_W'(r) < cnt) ? word_buf[r*X_BITS +: X_BITS]
                                                            : '0;
    end
  endgenerate

  always_comb begin
    n_words = '0;
    for (int j = 0; j < IN_WORDS; j++) begin
      n_words = n_words + N_W'(s_keep[j]);
    end
  end

  always_comb begin
    cnt_pop = cnt;
    buf_pop = word_buf;
    if (pop) begin
      buf_pop = word_buf >> (ROWS * X_BITS);
      if (m_last) begin
        cnt_pop = '0;
      end else if (cnt >= CNT_W'(ROWS)) begin
        cnt_pop = cnt - CNT_W'(ROWS);
      end else begin
        cnt_pop = '0;
      end
    end
  end

  // Push lands after whatever survives a same-cycle pop; keep holes are not compacted.
  always_comb begin
    buf_d  = buf_pop;
    cnt_d  = cnt_pop;
    last_d = last_pend;
    if (pop && m_last) begin
      last_d = 1'b0;
    end
    if (push) begin
      for (int j = 0; j < IN_WORDS; j++) begin
        if ((N_W'(j) < n_words) && ((int'(cnt_pop) + j) < BUF_WORDS)) begin
          buf_d[(int'(cnt_pop) + j)*X_BITS +: X_BITS] = s_data[j*X_BITS +: X_BITS];
        end
      end
      cnt_d = cnt_pop + CNT_W'(n_words);
      if (s_last) begin
        last_d = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      word_buf  <= '0;
      cnt       <= '0;
      last_pend <= 1'b0;
      rst_done  <= 1'b0;
    end else begin
      word_buf  <= buf_d;
      cnt       <= cnt_d;
      last_pend <= last_d;
      rst_done  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_pixels_unpack.sv
// Directed bench for axis_pixels_unpack: hand-computed output beats for
// reset, full/partial/empty packets, keep holes and a backpressure scoreboard run.
module tb_axis_pixels_unpack;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic [63:0] s_data = '0;
  logic [15:0] s_keep = '0;
  logic        m_ready = 1'b0;
  logic        s_ready, m_valid, m_last;
  logic [31:0] m_data;

  int tests = 0;
  int fails = 0;
  logic [32:0] got[$];

  always #5 aclk = ~aclk;

  axis_pixels_unpack dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_ready (s_ready),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_data  (s_data),
    .s_keep  (s_keep),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
  );

  // Inputs change at posedge+1, so the negedge sees the values the next edge will use.
  always @(negedge aclk) begin
    if (aresetn && m_valid && m_ready) got.push_back({m_last, m_data});
  end

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [15:0] k, input logic l);
    logic ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    for (int c = 0; c < 200; c++) begin
      if (s_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_beats(input int n);
    for (int c = 0; c < 200 && got.size() < n; c++) tick();
    tick();
    chk("beat_count", 64'(got.size()), 64'(n));
  endtask

  int          keep_n[6] = '{16, 3, 0, 16, 7, 9};
  logic [3:0]  exp_w[$];
  logic [32:0] ev;
  logic [31:0] stall_ref;
  int          bi, seq, acc, nb;
  int          stall_bad, ready_bad;
  logic        have_ref, saw_last;

  initial begin
    // reset state
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    tick();
    aresetn = 1'b1;
    chk("rel_s_ready_before_edge", 64'(s_ready), 64'd0);
    tick();
    chk("rel_s_ready_after_edge", 64'(s_ready), 64'd1);
    chk("rel_m_valid", 64'(m_valid), 64'd0);

    // full 16-word beat with last
    m_ready = 1'b1;
    got.delete();
    send_beat(64'hFEDC_BA98_7654_3210, 16'hFFFF, 1'b1);
    chk("full_latency_data", 64'(m_data), 64'h7654_3210);
    chk("full_first_valid", 64'(m_valid), 64'd1);
    chk("full_first_last", 64'(m_last), 64'd0);
    chk("full_s_ready_0", 64'(s_ready), 64'd0);
    tick();
    chk("full_second_data", 64'(m_data), 64'hFEDC_BA98);
    chk("full_second_last", 64'(m_last), 64'd1);
    chk("full_s_ready_1", 64'(s_ready), 64'd0);
    tick();
    chk("full_s_ready_back", 64'(s_ready), 64'd1);
    chk("full_idle_valid", 64'(m_valid), 64'd0);
    chk("full_beats", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      chk("full_beat0", 64'(got[0]), {31'd0, 1'b0, 32'h7654_3210});
      chk("full_beat1", 64'(got[1]), {31'd0, 1'b1, 32'hFEDC_BA98});
    end

    // 5+5+5+1 words, junk in dropped upper words
    got.delete();
    send_beat(64'hFFFF_FFFF_FFF5_4321, 16'h001F, 1'b0);
    send_beat(64'hEEEE_EEEE_EEEA_9876, 16'h001F, 1'b0);
    send_beat(64'hDDDD_DDDD_DDDF_EDCB, 16'h001F, 1'b0);
    send_beat(64'h1234_5678_9ABC_DEF0, 16'h0001, 1'b1);
    wait_beats(2);
    if (got.size() == 2) begin
      chk("multi_beat0", 64'(got[0]), {31'd0, 1'b0, 32'h8765_4321});
      chk("multi_beat1", 64'(got[1]), {31'd0, 1'b1, 32'h0FED_CBA9});
    end

    // 11-word partial flush
    got.delete();
    send_beat(64'h5555_5A98_7654_3210, 16'h07FF, 1'b1);
    wait_beats(2);
    if (got.size() == 2) begin
      chk("partial_beat0", 64'(got[0]), {31'd0, 1'b0, 32'h7654_3210});
      chk("partial_beat1", 64'(got[1]), {31'd0, 1'b1, 32'h0000_0A98});
    end

    // keep with holes: lowest popcount words taken
    got.delete();
    send_beat(64'h0000_0000_0000_DCBA, 16'h8421, 1'b1);
    wait_beats(1);
    if (got.size() == 1) chk("holes_beat", 64'(got[0]), {31'd0, 1'b1, 32'h0000_DCBA});

    // empty packet
    got.delete();
    send_beat(64'hFFFF_FFFF_FFFF_FFFF, 16'h0000, 1'b1);
    chk("empty_valid", 64'(m_valid), 64'd1);
    chk("empty_last", 64'(m_last), 64'd1);
    chk("empty_data", 64'(m_data), 64'd0);
    wait_beats(1);
    if (got.size() == 1) chk("empty_beat", 64'(got[0]), {31'd0, 1'b1, 32'h0});

    // zero-word beat without last changes nothing
    got.delete();
    send_beat(64'hFFFF_FFFF_FFFF_FFFF, 16'h0000, 1'b0);
    tick();
    chk("n0_valid", 64'(m_valid), 64'd0);
    chk("n0_s_ready", 64'(s_ready), 64'd1);
    chk("n0_beats", 64'(got.size()), 64'd0);

    // backpressure then random m_ready against scoreboard
    got.delete();
    exp_w.delete();
    bi = 0; seq = 0; acc = 0;
    stall_bad = 0; ready_bad = 0;
    have_ref = 1'b0; saw_last = 1'b0;
    stall_ref = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (bi < 6) begin
        s_valid = 1'b1;
        s_keep  = (keep_n[bi] == 16) ? 16'hFFFF : 16'((32'd1 << keep_n[bi]) - 1);
        s_last  = (bi == 5);
        for (int j = 0; j < 16; j++) s_data[j*4 +: 4] = 4'(seq + j);
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
      m_ready = (cyc < 40) ? 1'b0 : 1'($urandom_range(0, 1));
      if (cyc < 40) begin
        if (s_ready && acc > 8) ready_bad++;
        if (m_valid) begin
          if (!have_ref) begin
            stall_ref = m_data;
            have_ref  = 1'b1;
          end else if (m_data !== stall_ref) begin
            stall_bad++;
          end
        end
      end
      if (s_valid && s_ready) begin
        for (int j = 0; j < keep_n[bi]; j++) exp_w.push_back(4'(seq + j));
        seq += keep_n[bi];
        acc += keep_n[bi];
        bi++;
      end
      if (cyc == 39) begin
        chk("bp_stall_valid", 64'(m_valid), 64'd1);
        chk("bp_stall_words", 64'(acc), 64'd16);
      end
      tick();
      if (got.size() > 0 && got[got.size()-1][32]) begin
        saw_last = 1'b1;
        break;
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    chk("bp_finished", 64'(saw_last), 64'd1);
    chk("bp_data_stable", 64'(stall_bad), 64'd0);
    chk("bp_s_ready_low", 64'(ready_bad), 64'd0);
    nb = (exp_w.size() + 7) / 8;
    chk("bp_total_words", 64'(exp_w.size()), 64'd51);
    chk("bp_beats", 64'(got.size()), 64'(nb));
    for (int b = 0; b < nb; b++) begin
      ev = '0;
      for (int r = 0; r < 8; r++) begin
        if (b*8 + r < exp_w.size()) ev[r*4 +: 4] = exp_w[b*8 + r];
      end
      ev[32] = (b == nb - 1);
      if (b < got.size()) chk("bp_beat", 64'(got[b]), 64'(ev));
    end

    // reset mid-packet
    m_ready = 1'b0;
    tick();
    got.delete();
    send_beat(64'hFEDC_BA98_7654_3210, 16'hFFFF, 1'b0);
    chk("mid_valid_before", 64'(m_valid), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_last", 64'(m_last), 64'd0);
    chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
    chk("mid_rst_data", 64'(m_data), 64'd0);
    tick();
    aresetn = 1'b1;
    tick();
    chk("mid_rel_s_ready", 64'(s_ready), 64'd1);
    chk("mid_rel_valid", 64'(m_valid), 64'd0);
    m_ready = 1'b1;
    send_beat(64'h0000_0000_1357_9BDF, 16'h00FF, 1'b1);
    wait_beats(1);
    if (got.size() == 1) chk("mid_new_packet", 64'(got[0]), {31'd0, 1'b1, 32'h1357_9BDF});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
